// File: rtl/shiftin_chain.sv
// Scans a chain of 74HC165 parallel-in/serial-out registers and publishes the captured bits on d.
// Define SHIFTIN_DEBOUNCE_EN to filter each bit over DEBOUNCE_SCANS consecutive scans.
module shiftin_chain #(
   parameter int   NBYTES         = 2,
   parameter int   LOAD_TICKS     = 2,
   parameter logic DEFAULT_STATE  = 1'b1,
   parameter int   DEBOUNCE_SCANS = 3
) (
   input  logic                  clk28,
   input  logic                  usrrst_n,
   input  logic                  clk_en,
   input  logic                  auto_en,
   input  logic                  start,
   input  logic                  q,
   output logic                  cp,
   output logic                  pl,
   output logic [8*NBYTES-1:0]   d,
   output logic                  busy,
   output logic                  sync,
   output logic                  changed
);

   localparam int NBITS = 8 * NBYTES;
   localparam int CW    = $clog2(NBITS + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(NBITS);
   localparam logic [2:0]    LD_LAST  = 3'(LOAD_TICKS - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_SHIFT_LO = 3'd2,
      S_SHIFT_HI = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t             r_state;
   logic [2:0]         r_ldcnt;
   logic [CW-1:0]      r_bitcnt;
   logic [NBITS-1:0]   r_raw;
   logic               r_start_pend;
   logic [NBITS-1:0]   w_new_d;
   logic               w_done_entry;

   assign w_done_entry = clk_en && (r_state == S_SHIFT_HI) && (r_bitcnt == FULL_CNT);

`ifdef SHIFTIN_DEBOUNCE_EN
   localparam int HW = DEBOUNCE_SCANS - 1;

   // Previous HW raw samples per bit; a bit moves only when they all agree with the newest sample.
   logic [NBITS-1:0][HW-1:0] r_hist;

   // Shift the newest raw scan into each bit's history on every completed scan.
   always_ff @(posedge clk28 or negedge usrrst_n) begin
      if (!usrrst_n) begin
         r_hist <= {(NBITS*HW){DEFAULT_STATE}};
      end else if (w_done_entry) begin
         for (int i = 0; i < NBITS; i++) begin
            r_hist[i] <= HW'({r_hist[i], r_raw[i]});
         end
      end else begin
         r_hist <= r_hist;
      end
   end

   // Debounced candidate for d.
   always_comb begin
      w_new_d = d;
      for (int i = 0; i < NBITS; i++) begin
         if (r_hist[i] == {HW{r_raw[i]}}) begin
            w_new_d[i] = r_raw[i];
         end else begin
            w_new_d[i] = d[i];
         end
      end
   end
`else
   assign w_new_d = r_raw;
`endif

   // Scan sequencer with registered chain controls and result strobes.
   always_ff @(posedge clk28 or negedge usrrst_n) begin
      if (!usrrst_n) begin
         r_state      <= S_IDLE;
         r_ldcnt      <= 3'd0;
         r_bitcnt     <= '0;
         r_raw        <= '0;
         r_start_pend <= 1'b0;
         pl           <= 1'b1;
         cp           <= 1'b0;
         busy         <= 1'b0;
         sync         <= 1'b0;
         changed      <= 1'b0;
         d            <= {NBITS{DEFAULT_STATE}};
      end else begin
         sync    <= 1'b0;
         changed <= 1'b0;
         // A start between ticks is remembered only while idle; busy-time starts are dropped.
         if (start && (r_state == S_IDLE) && !clk_en) begin
            r_start_pend <= 1'b1;
         end
         if (clk_en) begin
            case (r_state)
               S_IDLE: begin
                  r_start_pend <= 1'b0;
                  if (start || r_start_pend || auto_en) begin
                     r_state  <= S_LOAD;
                     r_ldcnt  <= 3'd0;
                     r_bitcnt <= '0;
                     pl       <= 1'b0;
                     busy     <= 1'b1;
                  end
               end
               S_LOAD: begin
                  if (r_ldcnt == LD_LAST) begin
                     r_state <= S_SHIFT_LO;
                     pl      <= 1'b1;
                  end else begin
                     r_ldcnt <= r_ldcnt + 3'd1;
                  end
               end
               S_SHIFT_LO: begin
                  // q already shows the next bit, so sample before raising cp.
                  r_raw   <= {r_raw[NBITS-2:0], q};
                  if (r_bitcnt != FULL_CNT) begin
                     r_bitcnt <= r_bitcnt + {{(CW-1){1'b0}}, 1'b1};
                  end
                  r_state <= S_SHIFT_HI;
                  cp      <= 1'b1;
               end
               S_SHIFT_HI: begin
                  cp <= 1'b0;
                  if (r_bitcnt == FULL_CNT) begin
                     r_state <= S_DONE;
                     d       <= w_new_d;
                     sync    <= 1'b1;
                     changed <= (w_new_d != d);
                  end else begin
                     r_state <= S_SHIFT_LO;
                  end
               end
               S_DONE: begin
                  r_state <= S_IDLE;
                  busy    <= 1'b0;
               end
               default: begin
                  r_state <= S_IDLE;
                  pl      <= 1'b1;
                  cp      <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shiftin_chain.sv
// Directed bench for shiftin_chain: NBYTES=1, LOAD_TICKS=2, clk_en every 4th clk28 cycle,
// with a behavioural 74HC165 model driving q. Expectations follow SHIFTIN_DEBOUNCE_EN when defined.
module tb_shiftin_chain;

   logic       clk28 = 1'b0;
   logic       usrrst_n;
   logic       clk_en = 1'b0;
   logic       auto_en;
   logic       start;
   logic       q;
   logic       cp;
   logic       pl;
   logic [7:0] d;
   logic       busy;
   logic       sync;
   logic       changed;

   int n_checks = 0;
   int n_fail   = 0;

   shiftin_chain #(
      .NBYTES(1), .LOAD_TICKS(2), .DEFAULT_STATE(1'b1), .DEBOUNCE_SCANS(3)
   ) u_dut (
      .clk28(clk28), .usrrst_n(usrrst_n), .clk_en(clk_en), .auto_en(auto_en),
      .start(start), .q(q), .cp(cp), .pl(pl), .d(d), .busy(busy),
      .sync(sync), .changed(changed)
   );

   always #5 clk28 = ~clk28;

   int cyc = 0;
   // clk_en strobe every 4th cycle, changed away from the active edge.
   always @(negedge clk28) begin
      cyc    <= cyc + 1;
      clk_en <= ((cyc % 4) == 3);
   end

   // 74HC165 chain model: load while pl falls, shift on cp rise.
   logic [7:0] par = 8'h00;
   logic [7:0] sreg;
   always @(posedge cp or negedge pl) begin
      if (!pl) sreg <= par;
      else     sreg <= {sreg[6:0], 1'b0};
   end
   assign q = sreg[7];

   // Output monitor sampled on the falling edge.
   int n_sync = 0, n_chg = 0, n_bfall = 0, n_plow = 0, n_cprise = 0;
   int run = 0, hi_len = 0, lo_len = 0;
   logic prev_busy = 1'b0, prev_cp = 1'b0;
   always @(negedge clk28) begin
      if (sync) n_sync <= n_sync + 1;
      if (changed) n_chg <= n_chg + 1;
      if (!pl) n_plow <= n_plow + 1;
      if (cp && !prev_cp) n_cprise <= n_cprise + 1;
      if (prev_busy && !busy) n_bfall <= n_bfall + 1;
      if (busy !== prev_busy) begin
         if (prev_busy) hi_len <= run;
         else           lo_len <= run;
         run <= 1;
      end else begin
         run <= run + 1;
      end
      prev_busy <= busy;
      prev_cp   <= cp;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      usrrst_n = 1'b0;
      repeat (3) @(negedge clk28);
      usrrst_n = 1'b1;
      @(negedge clk28);
   endtask

   task automatic pulse_start();
      @(negedge clk28);
      start = 1'b1;
      @(negedge clk28);
      start = 1'b0;
   endtask

   // Wait for n_sync to exceed base, then for busy to drop; an expired bound counts as a failure.
   task automatic wait_done(input string tag, input int base);
      int t;
      t = 0;
      while (n_sync <= base && t < 400) begin @(negedge clk28); t++; end
      if (t >= 400) check({tag, "_sync_timeout"}, 32'd0, 32'd1);
      t = 0;
      while (busy && t < 100) begin @(negedge clk28); t++; end
      if (t >= 100) check({tag, "_busy_timeout"}, 32'd0, 32'd1);
      repeat (2) @(negedge clk28);
   endtask

   logic [7:0] seq   [6] = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFE};
`ifdef SHIFTIN_DEBOUNCE_EN
   logic [7:0] exp_d [6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
   logic       exp_c [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [7:0] single_d = 8'hFF;
   int         single_c = 0;
`else
   logic [7:0] exp_d [6] = '{8'hFF, 8'hFE, 8'hFF, 8'hFE, 8'hFE, 8'hFE};
   logic       exp_c [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic [7:0] single_d = 8'hA5;
   int         single_c = 1;
`endif

   initial begin
      int b_sync, b_chg, b_bf, b_pl, b_cp, t;
      usrrst_n = 1'b0;
      auto_en  = 1'b0;
      start    = 1'b0;
      repeat (3) @(negedge clk28);
      usrrst_n = 1'b1;

      // Idle after reset with no start.
      repeat (200) @(negedge clk28);
      check("idle_pl", pl, 1'b1);
      check("idle_cp", cp, 1'b0);
      check("idle_d", d, 8'hFF);
      check("idle_busy", busy, 1'b0);
      check("idle_no_scan", n_bfall, 0);
      check("idle_no_sync", n_sync, 0);

      // Single scan of 8'hA5.
      par = 8'hA5;
      b_sync = n_sync; b_chg = n_chg; b_bf = n_bfall; b_pl = n_plow; b_cp = n_cprise;
      pulse_start();
      wait_done("single", b_sync);
      check("single_d", d, single_d);
      check("single_sync", n_sync - b_sync, 1);
      check("single_changed", n_chg - b_chg, single_c);
      check("single_pl_cycles", n_plow - b_pl, 8);
      check("single_cp_pulses", n_cprise - b_cp, 8);
      check("single_busy_len", hi_len, 76);
      check("single_busy_fall", n_bfall - b_bf, 1);

      // Automatic back-to-back scans of 8'h3C.
      par = 8'h3C;
      b_sync = n_sync; b_chg = n_chg;
      @(negedge clk28);
      auto_en = 1'b1;
      t = 0;
      while (n_sync < b_sync + 4 && t < 1000) begin @(negedge clk28); t++; end
      check("auto_four_scans", (n_sync - b_sync) >= 4, 1'b1);
      t = 0;
      while (!busy && t < 20) begin @(negedge clk28); t++; end
      check("auto_restart", busy, 1'b1);
      check("auto_idle_gap", lo_len, 4);
      check("auto_busy_len", hi_len, 76);
      repeat (12) @(negedge clk28);
      auto_en = 1'b0;
      wait_done("auto_tail", b_sync + 4);
      repeat (100) @(negedge clk28);
      check("auto_scan_count", n_sync - b_sync, 5);
      check("auto_changed_once", n_chg - b_chg, 1);
      check("auto_d", d, 8'h3C);
      check("auto_stopped", busy, 1'b0);

      // Repeated start during a scan is ignored.
      par = 8'h5A;
      b_sync = n_sync; b_bf = n_bfall;
      pulse_start();
      t = 0;
      while (!busy && t < 20) begin @(negedge clk28); t++; end
      repeat (16) @(negedge clk28);
      pulse_start();
      wait_done("restart", b_sync);
      repeat (200) @(negedge clk28);
      check("restart_one_sync", n_sync - b_sync, 1);
      check("restart_one_fall", n_bfall - b_bf, 1);
      check("restart_busy", busy, 1'b0);

      // Reset in SHIFT_LO after four bits.
      do_reset();
      par = 8'h00;
      b_sync = n_sync; b_cp = n_cprise;
      pulse_start();
      t = 0;
      while (!((n_cprise - b_cp) == 4 && !cp) && t < 300) begin @(negedge clk28); t++; end
      check("abort_reached_bit4", n_cprise - b_cp, 4);
      usrrst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_pl", pl, 1'b1);
      check("abort_cp", cp, 1'b0);
      check("abort_d", d, 8'hFF);
      @(negedge clk28);
      usrrst_n = 1'b1;
      repeat (100) @(negedge clk28);
      check("abort_no_sync", n_sync - b_sync, 0);
      check("abort_stays_idle", busy, 1'b0);
      check("abort_d_after", d, 8'hFF);

      // Scan sequence FF FE FF FE FE FE from a fresh reset.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         par = seq[i];
         b_sync = n_sync; b_chg = n_chg;
         pulse_start();
         wait_done($sformatf("seq%0d", i), b_sync);
         check($sformatf("seq%0d_d", i), d, exp_d[i]);
         check($sformatf("seq%0d_sync", i), n_sync - b_sync, 1);
         check($sformatf("seq%0d_changed", i), n_chg - b_chg, exp_c[i]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
